// File: rtl/dot_score_tracker.sv
// dot_score_tracker
// Watches the dot tracker's eaten bitmap, credits each newly eaten dot to a
// saturating packed-BCD score (one dot per cycle, lowest bit first), reports
// how many dots remain, and runs the level-clear handshake with the game
// controller before re-arming for the next level.
//
// Ports:
//   Clk            in   system clock, rising edge
//   Reset          in   asynchronous active-low reset
//   eaten_vec      in   [NUM_DOTS-1:0] eaten bitmap (bit i = dot i eaten)
//   game_clear     in   synchronous pulse: zero score and pending queue
//   level_ack      in   controller acknowledge of level_clear
//   score_bcd      out  [4*SCORE_DIGITS-1:0] score, digit 0 in [3:0]
//   dots_remaining out  [5:0] NUM_DOTS - popcount(eaten_vec), registered
//   dot_event      out  one-cycle pulse per credited dot
//   level_clear    out  high while the level-complete handshake is pending
module dot_score_tracker #(
  parameter int NUM_DOTS     = 32,
  parameter int DOT_POINTS   = 10,
  parameter int SCORE_DIGITS = 5
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_DOTS-1:0]       eaten_vec,
  input  logic                      game_clear,
  input  logic                      level_ack,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [5:0]                dots_remaining,
  output logic                      dot_event,
  output logic                      level_clear
);

  localparam int SW = 4 * SCORE_DIGITS;
  localparam logic [3:0] UNITS = 4'(DOT_POINTS % 10);
  localparam logic [3:0] TENS  = 4'(DOT_POINTS / 10);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CLEAR = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_DOTS-1:0] prev_q;
  logic [NUM_DOTS-1:0] pending_q, pending_d;
  logic [SW-1:0]       score_q, score_d;
  logic [5:0]          remain_q, remain_d;
  logic                dot_event_q, dot_event_d;
  logic                level_clear_q, level_clear_d;

  logic [NUM_DOTS-1:0] rise;
  logic [NUM_DOTS-1:0] svc;
  logic [SW-1:0]       score_add;
  logic [SW-1:0]       score_sum;
  logic                overflow;

  function automatic logic [5:0] popcount(input logic [NUM_DOTS-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < NUM_DOTS; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

  assign rise = eaten_vec & ~prev_q;
  // Two's-complement trick isolates the lowest set bit of the queue.
  assign svc  = pending_q & ((~pending_q) + NUM_DOTS'(1));

  // Digit-serial BCD add of DOT_POINTS; a carry out of the top digit
  // means the true result would not fit, so the score pins at all nines.
  always_comb begin
    logic       carry;
    logic [4:0] dsum;
    logic [3:0] addend;
    score_add = '0;
    carry     = 1'b0;
    dsum      = '0;
    addend    = '0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      addend = (i == 0) ? UNITS : ((i == 1) ? TENS : 4'd0);
      dsum   = 5'(score_q[4*i +: 4]) + 5'(addend) + 5'(carry);
      if (dsum > 5'd9) begin
        score_add[4*i +: 4] = 4'(dsum - 5'd10);
        carry               = 1'b1;
      end else begin
        score_add[4*i +: 4] = dsum[3:0];
        carry               = 1'b0;
      end
    end
    // With a single digit the tens part of DOT_POINTS has nowhere to go.
    overflow  = carry || ((SCORE_DIGITS == 1) && (TENS != 4'd0));
    score_sum = overflow ? {SCORE_DIGITS{4'h9}} : score_add;
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    score_d     = score_q;
    dot_event_d = 1'b0;
    remain_d    = 6'(NUM_DOTS) - popcount(eaten_vec);

    if (game_clear) begin
      score_d   = '0;
      pending_d = '0;
      state_d   = PLAY;
    end else begin
      unique case (state_q)
        PLAY: begin
          pending_d = (pending_q & ~svc) | rise;
          if (|pending_q) begin
            score_d     = score_sum;
            dot_event_d = 1'b1;
          end
          // Level is complete only once every dot is eaten and fully credited.
          if ((&prev_q) && (pending_q == '0) && (rise == '0)) begin
            state_d = CLEAR;
          end
        end
        CLEAR: begin
          pending_d = '0;
          if (level_ack) begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          pending_d = '0;
          // Tracker re-arms by clearing its bitmap for the new level.
          if (eaten_vec == '0) begin
            state_d = PLAY;
          end
        end
        default: begin
          state_d   = PLAY;
          pending_d = '0;
        end
      endcase
    end

    level_clear_d = (state_d == CLEAR);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= PLAY;
      prev_q        <= '0;
      pending_q     <= '0;
      score_q       <= '0;
      remain_q      <= 6'(NUM_DOTS);
      dot_event_q   <= 1'b0;
      level_clear_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= eaten_vec;
      pending_q     <= pending_d;
      score_q       <= score_d;
      remain_q      <= remain_d;
      dot_event_q   <= dot_event_d;
      level_clear_q <= level_clear_d;
    end
  end

  assign score_bcd      = score_q;
  assign dots_remaining = remain_q;
  assign dot_event      = dot_event_q;
  assign level_clear    = level_clear_q;

endmodule
